// File: rtl/ks_pkg.sv
// ks_pkg: shared width, buffer-state enum and result struct (flags with KS_SUM_FLAGS_EN)
package ks_pkg;
    localparam int KS_WIDTH = 32;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;
    typedef struct packed {
        logic [KS_WIDTH-1:0] sum;
        logic                cout;
`ifdef KS_SUM_FLAGS_EN
        logic                zero;
        logic                neg;
        logic                ovf;
`endif
    } ks_result_t;
endpackage

// File: rtl/ks_sum_calc.sv
// ks_sum_calc: combinational Kogge-Stone sum, carry-out and optional flags (KS_SUM_FLAGS_EN)
module ks_sum_calc
    import ks_pkg::*;
(
    input  logic                i_c0,
    input  logic [KS_WIDTH-1:0] i_gk,
    input  logic [KS_WIDTH-1:0] i_p_save,
    output ks_result_t          o_res
);
    logic [KS_WIDTH-1:0] sum;
    // Carry into bit i is the group generate of bits i-1..0; c0 feeds bit 0.
    assign sum = i_p_save ^ {i_gk[KS_WIDTH-2:0], i_c0};
    always_comb begin
        o_res      = '0;
        o_res.sum  = sum;
        o_res.cout = i_gk[KS_WIDTH-1];
`ifdef KS_SUM_FLAGS_EN
        o_res.zero = (sum == '0);
        o_res.neg  = sum[KS_WIDTH-1];
        o_res.ovf  = i_gk[KS_WIDTH-2] ^ i_gk[KS_WIDTH-1];
`endif
    end
endmodule

// File: rtl/ks_sum_pipe.sv
// ks_sum_pipe: registered Kogge-Stone final sum stage with 2-entry valid/ready buffer.
// Status flag ports/storage exist only when KS_SUM_FLAGS_EN is defined.
module ks_sum_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_c0,
    input  logic [WIDTH-1:0] i_gk,
    input  logic [WIDTH-1:0] i_p_save,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
`ifdef KS_SUM_FLAGS_EN
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf,
`endif
    output logic             o_cout
);
    if (WIDTH != KS_WIDTH) begin : g_width_chk
        $error("ks_sum_pipe: WIDTH must be 32");
    end

    ks_result_t new_res;
    ks_result_t head_q, head_d, tail_q, tail_d;
    buf_state_e state_q, state_d;
    logic       ready_q, ready_d;
    logic       accept, drain;

    ks_sum_calc u_calc (
        .i_c0     (i_c0),
        .i_gk     (i_gk),
        .i_p_save (i_p_save),
        .o_res    (new_res)
    );

    assign accept = i_valid && ready_q;
    assign drain  = o_valid && i_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = new_res;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) head_d = new_res;
                else if (accept) begin
                    tail_d  = new_res;
                    state_d = FULL;
                end else if (drain) state_d = EMPTY;
            end
            FULL: begin
                if (drain) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Ready is registered off the next state so FULL->ONE reopens with no bubble.
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = (state_q != EMPTY);
    assign o_sum   = head_q.sum;
    assign o_cout  = head_q.cout;
`ifdef KS_SUM_FLAGS_EN
    assign o_zero  = head_q.zero;
    assign o_neg   = head_q.neg;
    assign o_ovf   = head_q.ovf;
`endif
endmodule

// File: tb/tb_ks_sum_pipe.sv
// tb_ks_sum_pipe: directed self-checking bench for ks_sum_pipe (flag checks with KS_SUM_FLAGS_EN)
module tb_ks_sum_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_c0 = 1'b0;
    logic [31:0] i_gk = '0;
    logic [31:0] i_p_save = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_sum;
    logic        o_cout;
`ifdef KS_SUM_FLAGS_EN
    logic        o_zero, o_neg, o_ovf;
`endif
    int n_vec = 0;
    int n_err = 0;

    ks_sum_pipe #(.WIDTH(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_c0     (i_c0),
        .i_gk     (i_gk),
        .i_p_save (i_p_save),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
`ifdef KS_SUM_FLAGS_EN
        .o_zero   (o_zero),
        .o_neg    (o_neg),
        .o_ovf    (o_ovf),
`endif
        .o_cout   (o_cout)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive a+b+c0 as stage-3 outputs, using a ripple carry to build gk.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c0);
        logic c;
        c = c0;
        for (int i = 0; i < 32; i++) begin
            c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
            i_gk[i] = c;
        end
        i_p_save = a ^ b;
        i_c0     = c0;
        i_valid  = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        n_vec++;
        if ({o_valid, o_ready, o_sum, o_cout} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b r=%b sum=%h c=%b, want 0 0 0 0", o_valid, o_ready, o_sum, o_cout);
        end
        i_rst = 1'b0;
        step();
        n_vec++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_release: got v=%b r=%b, want v=0 r=1", o_valid, o_ready);
        end
    endtask

    task automatic test_arith(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic c0, input logic [31:0] es, input logic ec, input logic [2:0] ef);
        i_ready = 1'b1;
        drive(a, b, c0);
        step();
        i_valid = 1'b0;
        n_vec++;
        if ({o_valid, o_sum, o_cout} !== {1'b1, es, ec}) begin
            n_err++;
            $display("FAIL %s: got v=%b sum=%h c=%b, want v=1 sum=%h c=%b", name, o_valid, o_sum, o_cout, es, ec);
        end
`ifdef KS_SUM_FLAGS_EN
        n_vec++;
        if ({o_zero, o_neg, o_ovf} !== ef) begin
            n_err++;
            $display("FAIL %s_flags: got zno=%b%b%b, want %b", name, o_zero, o_neg, o_ovf, ef);
        end
`else
        if (ef === 3'bxxx) $display("unused flags");
`endif
        step();
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: got v=%b, want 0", name, o_valid);
        end
    endtask

    task automatic test_stream();
        i_ready = 1'b0;
        drive(32'd100, 32'd1, 1'b0);
        step();
        n_vec++;
        if ({o_valid, o_ready, o_sum} !== {1'b1, 1'b1, 32'd101}) begin
            n_err++;
            $display("FAIL stream_w1: got v=%b r=%b sum=%h, want 1 1 %h", o_valid, o_ready, o_sum, 32'd101);
        end
        drive(32'd200, 32'd2, 1'b0);
        step();
        n_vec++;
        if ({o_valid, o_ready, o_sum} !== {1'b1, 1'b0, 32'd101}) begin
            n_err++;
            $display("FAIL stream_full: got v=%b r=%b sum=%h, want 1 0 %h", o_valid, o_ready, o_sum, 32'd101);
        end
        drive(32'd300, 32'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if ({o_valid, o_ready, o_sum} !== {1'b1, 1'b0, 32'd101}) begin
                n_err++;
                $display("FAIL stream_stall%0d: got v=%b r=%b sum=%h, want 1 0 %h", k, o_valid, o_ready, o_sum, 32'd101);
            end
        end
        i_ready = 1'b1;
        step();
        n_vec++;
        if ({o_valid, o_ready, o_sum} !== {1'b1, 1'b1, 32'd202}) begin
            n_err++;
            $display("FAIL stream_w2: got v=%b r=%b sum=%h, want 1 1 %h", o_valid, o_ready, o_sum, 32'd202);
        end
        step();
        i_valid = 1'b0;
        n_vec++;
        if ({o_valid, o_sum} !== {1'b1, 32'd304}) begin
            n_err++;
            $display("FAIL stream_w3: got v=%b sum=%h, want 1 %h", o_valid, o_sum, 32'd304);
        end
        step();
        n_vec++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL stream_end: got v=%b r=%b, want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a = 32'h1000_0000 * k + 32'd7 * k;
            drive(a, 32'hF000_0001, k[0]);
            step();
            n_vec++;
            if ({o_valid, o_ready, o_sum} !== {1'b1, 1'b1, a + 32'hF000_0001 + {31'd0, k[0]}}) begin
                n_err++;
                $display("FAIL b2b_%0d: got v=%b r=%b sum=%h, want 1 1 %h", k, o_valid, o_ready, o_sum,
                         a + 32'hF000_0001 + {31'd0, k[0]});
            end
        end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_full();
        i_ready = 1'b0;
        drive(32'd11, 32'd22, 1'b0);
        step();
        drive(32'd33, 32'd44, 1'b0);
        step();
        i_valid = 1'b0;
        n_vec++;
        if ({o_valid, o_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL rstfull_pre: got v=%b r=%b, want 1 0", o_valid, o_ready);
        end
        i_rst   = 1'b1;
        i_ready = 1'b1;
        step();
        i_rst = 1'b0;
        n_vec++;
        if ({o_valid, o_ready, o_sum, o_cout} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL rstfull_rst: got v=%b r=%b sum=%h c=%b, want 0 0 0 0", o_valid, o_ready, o_sum, o_cout);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if ({o_valid, o_ready, o_sum} !== {1'b0, 1'b1, 32'h0}) begin
                n_err++;
                $display("FAIL rstfull_after%0d: got v=%b r=%b sum=%h, want 0 1 0", k, o_valid, o_ready, o_sum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith("add_5_3", 32'd5, 32'd3, 1'b0, 32'h8, 1'b0, 3'b000);
        test_arith("wrap_zero", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 3'b100);
        test_arith("signed_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 3'b011);
        test_arith("carry_in", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 3'b000);
        test_stream();
        test_back_to_back();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
